// File: rtl/mem_arb_types.sv
// Shared types for the memory arbiter: FSM state encoding, arbitration
// mode constants and a small width helper used by the arbiter modules.
package mem_arb_types;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection. In round-robin mode the winner is the first
// requester strictly after last_grant, scanning upward modulo NUM_CH. In
// fixed mode the lowest requesting index wins and last_grant is ignored.
module arb_pick
    import mem_arb_types::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    input  logic              mode,
    output logic [IDX_W-1:0]  grant,
    output logic              valid
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back to the nearest so the nearest
    // requester is the last assignment and therefore wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        if (mode == ARB_FIXED) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                cand = IDX_W'(i);
                if (req[cand]) begin
                    grant = cand;
                    valid = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                cand = IDX_W'((int'(last_grant) + k) % NUM_CH);
                if (req[cand]) begin
                    grant = cand;
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-to-1 memory arbiter. One transaction is in flight at a time: a grant is
// made in IDLE, the winner's request is captured in a latch, and BUSY drives
// the downstream port purely from that latch until mem_resp completes it.
//
// Handshake: a requester raises ch_read and/or ch_write (level) and holds it
// until it sees its one-cycle ch_resp pulse; the arbiter holds mem_read or
// mem_write high, unchanged, until the memory answers with a one-cycle
// mem_resp. ch_rdata is meaningful only in the ch_resp cycle.
module mem_arbiter
    import mem_arb_types::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CH-1:0]                   ch_read,
    input  logic [NUM_CH-1:0]                   ch_write,
    input  logic [NUM_CH-1:0][DATA_W/8-1:0]     ch_byte_enable,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]       ch_address,
    input  logic [NUM_CH-1:0][DATA_W-1:0]       ch_wdata,
    output logic [NUM_CH-1:0]                   ch_resp,
    output logic [DATA_W-1:0]                   ch_rdata,
    output logic                                mem_read,
    output logic                                mem_write,
    output logic [DATA_W/8-1:0]                 mem_byte_enable,
    output logic [ADDR_W-1:0]                   mem_address,
    output logic [DATA_W-1:0]                   mem_wdata,
    input  logic                                mem_resp,
    input  logic [DATA_W-1:0]                   mem_rdata,
    output arb_state_t                          dbg_state
);

    localparam int   BE_W      = DATA_W / 8;
    localparam int   IDX_W     = idx_w(NUM_CH);
    localparam logic PICK_MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

    arb_state_t        state;
    arb_state_t        state_next;

    logic [NUM_CH-1:0] req;
    logic [IDX_W-1:0]  pick_grant;
    logic              pick_valid;
    logic [IDX_W-1:0]  last_grant;

    logic [IDX_W-1:0]  lat_grant;
    logic [ADDR_W-1:0] lat_address;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_byte_enable;
    logic              lat_write;

    assign req       = ch_read | ch_write;
    assign dbg_state = state;

    arb_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .mode       (PICK_MODE),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave IDLE on any request, leave BUSY on mem_resp.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = BUSY;
            BUSY:    if (mem_resp)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch and round-robin pointer, loaded on the IDLE->BUSY edge.
    // A simultaneous read and write on one channel is forwarded as a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant      <= IDX_W'(NUM_CH - 1);
            lat_grant       <= '0;
            lat_address     <= '0;
            lat_wdata       <= '0;
            lat_byte_enable <= '0;
            lat_write       <= 1'b0;
        end else if (state == IDLE && pick_valid) begin
            lat_grant       <= pick_grant;
            lat_address     <= ch_address[pick_grant];
            lat_wdata       <= ch_wdata[pick_grant];
            lat_byte_enable <= ch_byte_enable[pick_grant];
            lat_write       <= ch_write[pick_grant];
            if (PICK_MODE == ARB_RR) begin
                last_grant <= pick_grant;
            end
        end
    end

    // Downstream and requester-side outputs; address and wdata simply show
    // the latch, strobes and byte mask are qualified by BUSY.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_address     = lat_address;
        mem_wdata       = lat_wdata;
        ch_resp         = '0;
        ch_rdata        = '0;
        if (state == BUSY) begin
            mem_read        = ~lat_write;
            mem_write       = lat_write;
            mem_byte_enable = lat_byte_enable;
            if (mem_resp) begin
                ch_resp[lat_grant] = 1'b1;
                ch_rdata           = mem_rdata;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- NUM_CH, 2, number of requester ports, 2..8
- ADDR_W, 32, address width
- DATA_W, 32, data width, multiple of 8
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
REQ-002 SHALL have ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ch_read  in  NUM_CH  per-channel read request, level, held until ch_resp
- ch_write  in  NUM_CH  per-channel write request, level, held until ch_resp
- ch_byte_enable  in  NUM_CH x DATA_W/8  per-channel write byte mask
- ch_address  in  NUM_CH x ADDR_W  per-channel address
- ch_wdata  in  NUM_CH x DATA_W  per-channel write data
- ch_resp  out  NUM_CH  one-cycle completion pulse to the granted channel
- ch_rdata  out  DATA_W  read data, shared, valid only with ch_resp
- mem_read  out  1  downstream read request
- mem_write  out  1  downstream write request
- mem_byte_enable  out  DATA_W/8  downstream byte mask
- mem_address  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_resp  in  1  downstream completion
- mem_rdata  in  DATA_W  downstream read data

Function
REQ-003 SHALL use a two-state FSM:
- IDLE -> BUSY when any ch_read|ch_write is high at the clock edge.
- BUSY -> IDLE on the edge where mem_resp=1.
REQ-004 In IDLE, SHALL select the grant channel g combinationally and register g plus that channel's address, wdata, byte_enable and op into a request latch at the transition edge.
REQ-005 Latency: a request first seen in cycle N SHALL drive mem_read/mem_write in cycle N+1.
REQ-006 In BUSY, mem_* outputs SHALL come only from the request latch; changes on ch_* inputs SHALL NOT disturb an in-flight transaction.
REQ-007 In IDLE, mem_read, mem_write, mem_byte_enable and ch_resp SHALL be 0; mem_address and mem_wdata hold their last latched values.
REQ-008 In the cycle mem_resp=1 while in BUSY, SHALL assert ch_resp[g]=1 (all other bits 0) and ch_rdata=mem_rdata, combinationally.
REQ-009 mem_resp while in IDLE SHALL be ignored.
REQ-010 With ARB_MODE=0, SHALL grant the first requesting channel strictly after last_grant, scanning upward modulo NUM_CH, and SHALL update last_grant to g on grant.
REQ-011 With ARB_MODE=1, SHALL grant the lowest-index requesting channel; last_grant is unused.
REQ-012 If ch_read and ch_write are both high on one channel, SHALL forward a write (mem_write=1, mem_read=0).
REQ-013 A requester dropping its request while BUSY SHALL NOT abort the transaction; the response is still delivered.
REQ-014 Back-to-back: on the IDLE cycle after a response, SHALL re-arbitrate. A requester is expected to have dropped its completed request by then.
REQ-015 Write-only transactions SHALL still wait for mem_resp before returning to IDLE.

Reset
REQ-016 While rst=1 at an edge: state=IDLE, last_grant=NUM_CH-1, request latch address/wdata/byte_enable=0.
REQ-017 Consequently all outputs SHALL be 0 in the cycle after reset.
REQ-018 Reset during BUSY SHALL abandon the transaction without asserting ch_resp. A mem_resp arriving later SHALL be ignored.

Structure
REQ-019 The FSM state enum (arb_state_t) and the ARB_RR/ARB_FIXED mode constants SHALL live in a shared package mem_arb_types, next to rv32i_types.
REQ-020 Grant selection SHALL be one combinational sub-module, arb_pick (inputs: request vector, last_grant, mode; output: grant index and valid).

Verification
REQ-021 Reset check: rst=1 for 2 cycles, then release -> mem_read=mem_write=0, ch_resp=0; first lone ch_read[1] at address 0x100 -> mem_read=1, mem_address=0x100 exactly one cycle later.
REQ-022 Round-robin check: NUM_CH=4, ARB_MODE=0, all 4 channels hold ch_read, memory responds after 3 cycles each, each channel drops its request after its resp -> grant order 0,1,2,3; each ch_resp pulses exactly once.
REQ-023 Fixed-priority check: ARB_MODE=1, ch0 and ch2 request continuously, re-raising after each resp -> ch0 granted every time; ch2 starves.
REQ-024 Write check: ch1 writes address 0x40, wdata 0xDEADBEEF, byte_enable 4'b0011; ch1 alters wdata mid-BUSY -> downstream sees 0xDEADBEEF / 0011 throughout; ch_resp[1] is given on mem_resp.
REQ-025 Read data and reset-abort check: read returns mem_rdata=0x12345678 -> ch_rdata=0x12345678 in the same cycle as ch_resp[0]. Separately, rst pulsed during BUSY, then mem_resp=1 -> no ch_resp; state is IDLE.
REQ-026 Conflict check: ch_read[0] and ch_write[0] both high -> mem_write=1, mem_read=0.
